// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the multi-cycle arithmetic
//               controllers: FSM state encoding and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // FSM state encoding, common to all multi-cycle arithmetic controllers
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Bit-counter width: $clog2(w), but never narrower than one bit so that
    // WIDTH=1 still has a real (single-value) counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_bit.sv
`default_nettype none
// ============================================================================
// Module      : adder_bit
// Description : Single-bit combinational full adder.
// Ports       : a, b       - addend bits
//               carry_in   - incoming carry
//               sum        - a ^ b ^ carry_in
//               carry_out  - majority(a, b, carry_in)
// Revision    : 1.0 - initial release
// ============================================================================
module adder_bit (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    logic w_half;

    assign w_half    = a ^ b;
    assign sum       = w_half ^ carry_in;
    assign carry_out = (a & b) | (carry_in & w_half);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder. Sequences one adder_bit cell over WIDTH
//               cycles to compute {carry_out, sum} = a + b + carry_in.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               start         - request (accepted in IDLE or DONE only)
//               a, b, carry_in- operands, captured on an accepted start
//               busy          - high while the FSM is in RUN
//               done          - one-cycle pulse, new result valid
//               sum, carry_out- last completed result (held)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int                  c_cnt_w    = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0]  c_last_cnt = c_cnt_w'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry_out;

    logic               w_bit_sum;
    logic               w_bit_carry;
    logic               w_accept;
    logic               w_run;
    logic [WIDTH-1:0]   w_acc_next;

    assign w_run    = (r_state == S_RUN);
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    adder_bit u_adder_bit (
        .a         (r_sa[0]),
        .b         (r_sb[0]),
        .carry_in  (r_carry),
        .sum       (w_bit_sum),
        .carry_out (w_bit_carry)
    );

    // The working register shifts right with each new sum bit entering at
    // the top. Its bit 0 is shifted out every cycle and never observed, so
    // only acc[WIDTH-1:1] is kept in flops.
    generate
        if (WIDTH == 1) begin : g_acc_one
            assign w_acc_next = w_bit_sum;
        end else begin : g_acc_wide
            logic [WIDTH-2:0] r_acc_hi;

            assign w_acc_next = {w_bit_sum, r_acc_hi};

            always_ff @(posedge clk) begin
                if (rst || w_accept) begin
                    r_acc_hi <= '0;
                end else if (w_run) begin
                    r_acc_hi <= w_acc_next[WIDTH-1:1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sa        <= '0;
            r_sb        <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_carry <= carry_in;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_carry <= w_bit_carry;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last_cnt) begin
                        r_sum       <= w_acc_next;
                        r_carry_out <= w_bit_carry;
                        r_state     <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = w_run;
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign carry_out = r_carry_out;

endmodule
`default_nettype wire
